// File: rtl/sqrt_sequencer.sv
// sqrt_sequencer
// ---------------------------------------------------------------------------
// Computes root = sqrt(n) for an IEEE-754 single-precision operand using
// Babylonian iteration x(k+1) = (x(k) + n/x(k)) / 2. It drives one external
// floating-point adder and one external divider over stb/ack handshakes.
// The halving step is done locally by decrementing the exponent field.
//
// Optional build macro: NEG_CHECK_EN
//   defined   : a nonzero negative non-NaN operand returns the quiet NaN
//               32'h7FC00000 with err=1.
//   undefined : the sign bit is dropped when the operand is latched, so
//               sqrt(|n|) is returned with err=0.
//
// Parameters
//   MAX_ITER  iteration cap (1..31)
//   EPS       convergence threshold (positive single); iteration stops when
//             |x(k+1) - x(k)| < EPS
//
// Ports
//   CLK, RST            clock, synchronous active-high reset (shared with
//                       the attached adder and divider)
//   start, n            request strobe and operand (sampled in IDLE only)
//   busy                request in progress
//   done                one-cycle completion pulse
//   root, err, iters    result, invalid-operand flag, iterations used;
//                       these hold until the next request completes
//   add_*               adder master: a/b operand handshakes, z result
//   div_*               divider master: a/b operand handshakes, z result
// ---------------------------------------------------------------------------
module sqrt_sequencer #(
  parameter int          MAX_ITER = 16,
  parameter logic [31:0] EPS      = 32'h358637BD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] n,
  output logic        busy,
  output logic        done,
  output logic [31:0] root,
  output logic        err,
  output logic [4:0]  iters,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_a_stb,
  output logic        div_b_stb,
  input  logic        div_a_ack,
  input  logic        div_b_ack,
  input  logic [31:0] div_z,
  input  logic        div_z_stb,
  output logic        div_z_ack
);

  localparam logic [4:0]  ITER_CAP = 5'(MAX_ITER);
  localparam logic [31:0] ONE      = 32'h3F800000;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE, SPECIAL, DIV, ADD, HALF, SUB, CHECK, FIN
  } state_t;

  state_t state, state_n;

  logic [31:0] n_r;     // latched operand
  logic [31:0] x;       // current estimate
  logic [31:0] sum;     // x + n/x
  logic [31:0] xn;      // next estimate
  logic [30:0] diff;    // |xn - x| (sign is irrelevant for the test)
  logic [4:0]  cnt;     // iterations completed
  logic        err_r;

  // combinational helpers
  logic [31:0] x_d;     // estimate forwarded into the next DIV
  logic [31:0] x0;
  logic [31:0] half_v;
  logic [31:0] spec_root;
  logic        spec_err;
  logic        is_special;
  logic        conv;
  logic        last;
  logic        enter_div;
  logic        enter_add;
  logic        enter_sub;

  //--------------------------------------------------------------------------
  // operand classification and per-step arithmetic
  //--------------------------------------------------------------------------
  always_comb begin
    is_special = 1'b0;
    spec_root  = n_r;
    spec_err   = 1'b0;
    if (n_r[30:23] == 8'd0) begin
      is_special = 1'b1;                 // zero or denormal: pass through
    end else if (n_r[30:23] == 8'hFF) begin
      is_special = 1'b1;                 // inf passes, NaN flags err
      spec_err   = |n_r[22:0];
`ifdef NEG_CHECK_EN
    end else if (n_r[31]) begin
      is_special = 1'b1;
      spec_root  = QNAN;
      spec_err   = 1'b1;
`endif
    end

    // start from n for n >= 1.0, otherwise from 1.0, so x0 >= sqrt(n)
    x0 = (n_r[30:23] >= 8'd127) ? n_r : ONE;

    // divide by two: decrement the exponent, flush to +0 on underflow
    if (sum[30:23] <= 8'd1) half_v = 32'h0;
    else                    half_v = {sum[31], sum[30:23] - 8'd1, sum[22:0]};

    conv = diff < EPS[30:0];
    last = (cnt + 5'd1) == ITER_CAP;
  end

  // Result acks are combinational so the ack cycle never overlaps the next
  // unit's operand strobes (DIV hands straight over to ADD).
  assign div_z_ack = (state == DIV) && !div_a_stb && !div_b_stb && div_z_stb;
  assign add_z_ack = ((state == ADD) || (state == SUB)) &&
                     !add_a_stb && !add_b_stb && add_z_stb;

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    x_d     = x;
    case (state)
      IDLE:    if (start) state_n = SPECIAL;
      SPECIAL: begin
        if (is_special) begin
          state_n = FIN;
        end else begin
          state_n = DIV;
          x_d     = x0;
        end
      end
      DIV:     if (div_z_ack) state_n = ADD;
      ADD:     if (add_z_ack) state_n = HALF;
      HALF:    state_n = SUB;
      SUB:     if (add_z_ack) state_n = CHECK;
      CHECK: begin
        x_d     = xn;
        state_n = (conv || last) ? FIN : DIV;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    enter_div = (state_n == DIV) && (state != DIV);
    enter_add = (state_n == ADD) && (state != ADD);
    enter_sub = (state_n == SUB) && (state != SUB);
  end

  //--------------------------------------------------------------------------
  // datapath, unit strobes and result registers
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      root      <= '0;
      err       <= 1'b0;
      iters     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      div_a_stb <= 1'b0;
      div_b_stb <= 1'b0;
      n_r       <= '0;
      x         <= '0;
      sum       <= '0;
      xn        <= '0;
      diff      <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
    end else begin
      done <= 1'b0;

      // each strobe drops the cycle after its ack is seen
      if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
      if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
      if (div_a_stb && div_a_ack) div_a_stb <= 1'b0;
      if (div_b_stb && div_b_ack) div_b_stb <= 1'b0;

      // operands and strobes are presented on the state-entry cycle
      if (enter_div) begin
        div_a     <= n_r;
        div_b     <= x_d;
        div_a_stb <= 1'b1;
        div_b_stb <= 1'b1;
      end
      if (enter_add) begin
        add_a     <= x;
        add_b     <= div_z;        // quotient captured on this edge
        add_a_stb <= 1'b1;
        add_b_stb <= 1'b1;
      end
      if (enter_sub) begin
        add_a     <= half_v;
        add_b     <= {~x[31], x[30:0]};
        add_a_stb <= 1'b1;
        add_b_stb <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
`ifdef NEG_CHECK_EN
            n_r <= n;
`else
            n_r <= {1'b0, n[30:0]};
`endif
            busy  <= 1'b1;
            cnt   <= '0;
            err_r <= 1'b0;
          end
        end
        SPECIAL: begin
          if (is_special) begin
            x     <= spec_root;
            err_r <= spec_err;
          end else begin
            x     <= x_d;
          end
        end
        ADD:   if (add_z_ack) sum <= add_z;
        HALF:  xn <= half_v;
        SUB:   if (add_z_ack) diff <= add_z[30:0];
        CHECK: begin
          x   <= xn;
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          root  <= x;
          err   <= err_r;
          iters <= cnt;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_sequencer.sv
// tb_sqrt_sequencer
// Directed bench for sqrt_sequencer. Two instances: u0 with default
// parameters, u1 with MAX_ITER=2. Each unit port set is served by a
// behavioural adder/divider with optional random 0-5 cycle delays.
module tb_sqrt_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start [2];
  logic [31:0] n     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] root  [2];
  logic        err   [2];
  logic [4:0]  iters [2];

  // unit index k = 2*dut + (0: adder, 1: divider)
  logic [31:0] ua [4];
  logic [31:0] ub [4];
  logic        uas[4];
  logic        ubs[4];
  logic        uaa[4];
  logic        uba[4];
  logic [31:0] uz [4];
  logic        uzs[4];
  logic        uza[4];

  bit rnd_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  sqrt_sequencer u0 (
    .CLK(clk), .RST(rst), .start(start[0]), .n(n[0]),
    .busy(busy[0]), .done(done[0]), .root(root[0]), .err(err[0]), .iters(iters[0]),
    .add_a(ua[0]), .add_b(ub[0]), .add_a_stb(uas[0]), .add_b_stb(ubs[0]),
    .add_a_ack(uaa[0]), .add_b_ack(uba[0]), .add_z(uz[0]), .add_z_stb(uzs[0]),
    .add_z_ack(uza[0]),
    .div_a(ua[1]), .div_b(ub[1]), .div_a_stb(uas[1]), .div_b_stb(ubs[1]),
    .div_a_ack(uaa[1]), .div_b_ack(uba[1]), .div_z(uz[1]), .div_z_stb(uzs[1]),
    .div_z_ack(uza[1])
  );

  sqrt_sequencer #(.MAX_ITER(2)) u1 (
    .CLK(clk), .RST(rst), .start(start[1]), .n(n[1]),
    .busy(busy[1]), .done(done[1]), .root(root[1]), .err(err[1]), .iters(iters[1]),
    .add_a(ua[2]), .add_b(ub[2]), .add_a_stb(uas[2]), .add_b_stb(ubs[2]),
    .add_a_ack(uaa[2]), .add_b_ack(uba[2]), .add_z(uz[2]), .add_z_stb(uzs[2]),
    .add_z_ack(uza[2]),
    .div_a(ua[3]), .div_b(ub[3]), .div_a_stb(uas[3]), .div_b_stb(ubs[3]),
    .div_a_ack(uaa[3]), .div_b_ack(uba[3]), .div_z(uz[3]), .div_z_stb(uzs[3]),
    .div_z_ack(uza[3])
  );

  // ---------------- single <-> real helpers (denormals flushed) ----------
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0)       d = {s[31], 63'b0};
    else if (s[30:23] == 8'hFF) d = {s[31], 11'h7FF, s[22:0], 29'b0};
    else                        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'b0};
    e = e - 1023 + 127;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;   // round to nearest even
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic int rnd();
    return rnd_en ? int'($urandom_range(5, 0)) : 0;
  endfunction

  // ---------------- behavioural adder / divider -------------------------
  for (genvar k = 0; k < 4; k++) begin : g_unit
    int          ca, cb, cz;
    logic        ga, gb;
    logic [31:0] va, vb;
    int          xfer = 0;
    always @(posedge clk) begin
      if (rst) begin
        uaa[k] <= 1'b0; uba[k] <= 1'b0; uzs[k] <= 1'b0; uz[k] <= '0;
        ga <= 1'b0; gb <= 1'b0; ca <= 0; cb <= 0; cz <= 0;
      end else begin
        if (uaa[k])             uaa[k] <= 1'b0;
        else if (!uas[k] || ga) ca <= rnd();
        else if (ca != 0)       ca <= ca - 1;
        else begin uaa[k] <= 1'b1; ga <= 1'b1; va <= ua[k]; end

        if (uba[k])             uba[k] <= 1'b0;
        else if (!ubs[k] || gb) cb <= rnd();
        else if (cb != 0)       cb <= cb - 1;
        else begin uba[k] <= 1'b1; gb <= 1'b1; vb <= ub[k]; end

        if (uzs[k]) begin
          if (uza[k]) begin
            uzs[k] <= 1'b0; ga <= 1'b0; gb <= 1'b0; xfer <= xfer + 1;
          end
        end else if (ga && gb) begin
          if (cz != 0) cz <= cz - 1;
          else begin
            uzs[k] <= 1'b1;
            if (k % 2 == 0) uz[k] <= r2s(s2r(va) + s2r(vb));
            else            uz[k] <= r2s(s2r(va) / s2r(vb));
          end
        end else begin
          cz <= rnd();
        end
      end
    end
  end

  // ---------------- activity monitors ------------------------------------
  int stb_cnt [2] = '{0, 0};
  int excl_bad[2] = '{0, 0};
  int done_cnt[2] = '{0, 0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (uas[2*d] | ubs[2*d] | uas[2*d+1] | ubs[2*d+1]) stb_cnt[d] <= stb_cnt[d] + 1;
      if ((uas[2*d] | ubs[2*d] | uza[2*d]) && (uas[2*d+1] | ubs[2*d+1] | uza[2*d+1]))
        excl_bad[d] <= excl_bad[d] + 1;
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  // ---------------- tasks -------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int d, input logic [31:0] v);
    @(negedge clk);
    n[d]     = v;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  // returns edges counted from the accepting edge (1 = that edge)
  task automatic wait_done(input int d, input string tag, output int lat);
    lat = 1;
    while (done[d] !== 1'b1 && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " done"}, 32'(done[d]), 32'd1);
  endtask

  task automatic run(input int d, input logic [31:0] v, input string tag, output int lat);
    launch(d, v);
    wait_done(d, tag, lat);
  endtask

  // ---------------- directed sequence ------------------------------------
  initial begin
    int lat, s0, a0, q0, c0;
    logic [31:0] r2, it2, dl;
    start[0] = 1'b0; start[1] = 1'b0;
    n[0] = '0; n[1] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  32'(busy[0]), 32'd0);
    check("rst done",  32'(done[0]), 32'd0);
    check("rst root",  root[0], 32'd0);
    check("rst err",   32'(err[0]), 32'd0);
    check("rst iters", 32'(iters[0]), 32'd0);
    check("rst stb",   32'({uas[0], ubs[0], uas[1], ubs[1]}), 32'd0);
    check("rst div_a", ua[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // sqrt(4.0)
    run(0, 32'h40800000, "sqrt4", lat);
    check("sqrt4 root",  root[0], 32'h40000000);
    check("sqrt4 err",   32'(err[0]), 32'd0);
    check("sqrt4 iters", 32'(iters[0] >= 5'd1 && iters[0] <= 5'd16), 32'd1);
    check("sqrt4 busy",  32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    check("sqrt4 pulse", 32'(done[0]), 32'd0);

    // sqrt(2.0), immediate handshakes then random delays
    run(0, 32'h40000000, "sqrt2", lat);
    r2  = root[0];
    it2 = 32'(iters[0]);
    dl  = (r2 > 32'h3FB504F3) ? r2 - 32'h3FB504F3 : 32'h3FB504F3 - r2;
    check("sqrt2 ulp", 32'(dl <= 32'd1), 32'd1);
    rnd_en = 1'b1;
    run(0, 32'h40000000, "sqrt2 rnd", lat);
    check("sqrt2 rnd root",  root[0], r2);
    check("sqrt2 rnd iters", 32'(iters[0]), it2);
    rnd_en = 1'b0;

    // zero: fixed latency, no unit traffic
    s0 = stb_cnt[0];
    run(0, 32'h00000000, "zero", lat);
    check("zero lat",   32'(lat), 32'd3);
    check("zero root",  root[0], 32'd0);
    check("zero err",   32'(err[0]), 32'd0);
    check("zero iters", 32'(iters[0]), 32'd0);
    check("zero stb",   32'(stb_cnt[0] - s0), 32'd0);

    // negative operand
    run(0, 32'hC0800000, "neg", lat);
`ifdef NEG_CHECK_EN
    check("neg root", root[0], 32'h7FC00000);
    check("neg err",  32'(err[0]), 32'd1);
    check("neg lat",  32'(lat), 32'd3);
`else
    check("neg root", root[0], 32'h40000000);
    check("neg err",  32'(err[0]), 32'd0);
`endif

    // NaN and infinity
    run(0, 32'h7FC00001, "nan", lat);
    check("nan lat",  32'(lat), 32'd3);
    check("nan root", root[0], 32'h7FC00001);
    check("nan err",  32'(err[0]), 32'd1);
    run(0, 32'h7F800000, "inf", lat);
    check("inf root", root[0], 32'h7F800000);
    check("inf err",  32'(err[0]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("hold root", root[0], 32'h7F800000);

    // start while busy is ignored
    launch(0, 32'h40800000);
    repeat (2) @(posedge clk);
    launch(0, 32'h00000000);
    wait_done(0, "busy start", lat);
    check("busy start root", root[0], 32'h40000000);

    // iteration cap on u1
    a0 = g_unit[2].xfer;
    q0 = g_unit[3].xfer;
    run(1, 32'h7149F2CA, "cap", lat);
    check("cap iters", 32'(iters[1]), 32'd2);
    check("cap divs",  32'(g_unit[3].xfer - q0), 32'd2);
    check("cap adds",  32'(g_unit[2].xfer - a0), 32'd4);
    s0 = stb_cnt[1];
    repeat (20) @(posedge clk);
    #1;
    check("cap idle stb", 32'(stb_cnt[1] - s0), 32'd0);

    // reset while a division is outstanding
    launch(0, 32'h40800000);
    lat = 0;
    while (uas[1] !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("mid div stb seen", 32'(uas[1]), 32'd1);
    c0  = done_cnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid rst stb",  32'({uas[0], ubs[0], uas[1], ubs[1], uza[0], uza[1]}), 32'd0);
    check("mid rst busy", 32'(busy[0]), 32'd0);
    check("mid rst done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid no done", 32'(done_cnt[0] - c0), 32'd0);
    run(0, 32'h40800000, "after rst", lat);
    check("after rst root", root[0], 32'h40000000);
    check("after rst err",  32'(err[0]), 32'd0);

    check("exclusive u0", 32'(excl_bad[0]), 32'd0);
    check("exclusive u1", 32'(excl_bad[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
